// File: rtl/tto_console_writer.sv
// Teletype console writer: turns a character stream into VRAM port B cell writes,
// tracks the cursor and clears/scrolls the 80x32 colour text screen in hardware.
module tto_console_writer #(
    parameter int unsigned COLS           = 80,
    parameter int unsigned ROWS           = 30,
    parameter logic [7:0]  BLANK_COLOR    = 8'hFF,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_color,
    output logic        char_ready,
    output logic        vram_b_en,
    output logic        vram_b_we,
    output logic [12:0] vram_b_addr,
    output logic [15:0] vram_b_wdata,
    input  logic [15:0] vram_b_rdata,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        CLEAR      = 3'd2,
        SCROLL_RD  = 3'd3,
        SCROLL_WR  = 3'd4,
        SCROLL_CLR = 3'd5
    } state_t;

    localparam logic [6:0]  LAST_X     = 7'(COLS - 1);
    localparam logic [4:0]  LAST_Y     = 5'(ROWS - 1);
    localparam logic [4:0]  LAST_DST_Y = 5'(ROWS - 2);
    localparam logic [11:0] CLR_CELLS  = 12'(32 * COLS);
    localparam logic [15:0] BLANK_CELL = {BLANK_COLOR, 8'h20};

    function automatic logic [12:0] cell_addr(input logic [6:0] x, input logic [4:0] y);
        cell_addr = {1'b0, x, y};
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        is_printable = (c >= 8'h20) && (c != 8'h7F);
    endfunction

    function automatic logic [6:0] tab_stop(input logic [6:0] x);
        logic [7:0] t;
        t = {1'b0, x | 7'd7} + 8'd1;
        if (t > {1'b0, LAST_X}) begin
            tab_stop = LAST_X;
        end else begin
            tab_stop = t[6:0];
        end
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [4:0]  cur_y_q, cur_y_d;
    logic [6:0]  sx_q, sx_d;
    logic [4:0]  sy_q, sy_d;
    logic [6:0]  end_x_q, end_x_d;
    logic [11:0] clr_cnt_q, clr_cnt_d;
    logic        en_q, en_d;
    logic        we_q, we_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q;
    logic        busy_q;
    logic        accept_s;
    logic        scroll_start_s;

    assign accept_s = char_valid && ready_q;

    // Next state, cursor and next-cycle VRAM strobes.
    always_comb begin
        state_d        = state_q;
        cur_x_d        = cur_x_q;
        cur_y_d        = cur_y_q;
        sx_d           = sx_q;
        sy_d           = sy_q;
        end_x_d        = end_x_q;
        clr_cnt_d      = clr_cnt_q;
        en_d           = 1'b0;
        we_d           = 1'b0;
        addr_d         = 13'd0;
        wdata_d        = 16'h0000;
        scroll_start_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (is_printable(char_data)) begin
                        state_d = WRITE;
                        en_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = cell_addr(cur_x_q, cur_y_q);
                        wdata_d = {char_color, char_data};
                    end else begin
                        case (char_data)
                            8'h0D: cur_x_d = 7'd0;
                            8'h0A: begin
                                if (cur_y_q < LAST_Y) begin
                                    cur_y_d = cur_y_q + 5'd1;
                                end else begin
                                    scroll_start_s = 1'b1;
                                    end_x_d        = cur_x_q;
                                end
                            end
                            8'h08: begin
                                if (cur_x_q != 7'd0) begin
                                    cur_x_d = cur_x_q - 7'd1;
                                end else begin
                                    cur_x_d = cur_x_q;
                                end
                            end
                            8'h09: cur_x_d = tab_stop(cur_x_q);
                            8'h0C: begin
                                state_d   = CLEAR;
                                en_d      = 1'b1;
                                we_d      = 1'b1;
                                addr_d    = 13'd0;
                                wdata_d   = BLANK_CELL;
                                clr_cnt_d = 12'd1;
                            end
                            default: cur_x_d = cur_x_q;
                        endcase
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                if (cur_x_q < LAST_X) begin
                    cur_x_d = cur_x_q + 7'd1;
                    state_d = IDLE;
                end else if (cur_y_q < LAST_Y) begin
                    cur_x_d = 7'd0;
                    cur_y_d = cur_y_q + 5'd1;
                    state_d = IDLE;
                end else begin
                    // Auto-wrap on the last row: x lands on 0 once the scroll finishes.
                    scroll_start_s = 1'b1;
                    end_x_d        = 7'd0;
                end
            end

            CLEAR: begin
                if (clr_cnt_q < CLR_CELLS) begin
                    en_d      = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = {1'b0, clr_cnt_q};
                    wdata_d   = BLANK_CELL;
                    clr_cnt_d = clr_cnt_q + 12'd1;
                end else begin
                    state_d   = IDLE;
                    clr_cnt_d = 12'd0;
                    cur_x_d   = 7'd0;
                    cur_y_d   = 5'd0;
                end
            end

            SCROLL_RD: begin
                state_d = SCROLL_WR;
                en_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = cell_addr(sx_q, sy_q);
            end

            SCROLL_WR: begin
                if (sx_q < LAST_X) begin
                    state_d = SCROLL_RD;
                    sx_d    = sx_q + 7'd1;
                    en_d    = 1'b1;
                    addr_d  = cell_addr(sx_q + 7'd1, sy_q + 5'd1);
                end else if (sy_q < LAST_DST_Y) begin
                    state_d = SCROLL_RD;
                    sx_d    = 7'd0;
                    sy_d    = sy_q + 5'd1;
                    en_d    = 1'b1;
                    addr_d  = cell_addr(7'd0, sy_q + 5'd2);
                end else begin
                    state_d = SCROLL_CLR;
                    sx_d    = 7'd0;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = cell_addr(7'd0, LAST_Y);
                    wdata_d = BLANK_CELL;
                end
            end

            SCROLL_CLR: begin
                if (sx_q < LAST_X) begin
                    sx_d    = sx_q + 7'd1;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = cell_addr(sx_q + 7'd1, LAST_Y);
                    wdata_d = BLANK_CELL;
                end else begin
                    state_d = IDLE;
                    cur_x_d = end_x_q;
                    cur_y_d = LAST_Y;
                end
            end

            default: state_d = IDLE;
        endcase

        // First read of a scroll: source row 1 feeds destination row 0.
        if (scroll_start_s) begin
            state_d = SCROLL_RD;
            sx_d    = 7'd0;
            sy_d    = 5'd0;
            en_d    = 1'b1;
            we_d    = 1'b0;
            addr_d  = cell_addr(7'd0, 5'd1);
            wdata_d = 16'h0000;
        end else begin
            sy_d = sy_d;
        end
    end

    // State, cursor and registered VRAM/handshake outputs.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cur_x_q   <= 7'd0;
            cur_y_q   <= 5'd0;
            sx_q      <= 7'd0;
            sy_q      <= 5'd0;
            end_x_q   <= 7'd0;
            clr_cnt_q <= 12'd0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 13'd0;
            wdata_q   <= 16'h0000;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            end_x_q   <= end_x_d;
            clr_cnt_q <= clr_cnt_d;
            en_q      <= en_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign char_ready   = ready_q;
    assign busy         = busy_q;
    assign vram_b_en    = en_q;
    assign vram_b_we    = we_q;
    assign vram_b_addr  = addr_q;
    // Scroll copy forwards the read data straight through so colour is preserved.
    assign vram_b_wdata = (state_q == SCROLL_WR) ? vram_b_rdata : wdata_q;
    assign cursor_x     = cur_x_q;
    assign cursor_y     = cur_y_q;

endmodule

// File: tb/tb_tto_console_writer.sv
// Bench for tto_console_writer: VRAM model on port B plus a screen/cursor reference model.
module tb_tto_console_writer;

    logic        clk_pix = 1'b0;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic [7:0]  char_color;
    logic        char_ready;
    logic        vram_b_en;
    logic        vram_b_we;
    logic [12:0] vram_b_addr;
    logic [15:0] vram_b_wdata;
    logic [15:0] vram_b_rdata;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] mem [0:8191];
    logic [15:0] rdata_q = 16'h0000;
    logic [15:0] scr [0:79][0:31];
    int          mx, my, exp_busy, exp_wr;
    int          m_busy, m_wr, m_en, m_rlow, m_badaddr, m_nonblank;
    logic [12:0] m_addr;
    logic [15:0] m_data;
    bit          seen [0:2559];
    logic [7:0]  row_ch  [0:79];
    logic [7:0]  row_col [0:79];

    always #5 clk_pix = ~clk_pix;

    assign vram_b_rdata = rdata_q;

    // Port B VRAM: synchronous write, one-cycle read latency.
    always @(posedge clk_pix) begin
        if (vram_b_en) begin
            if (vram_b_we) mem[vram_b_addr] <= vram_b_wdata;
            else           rdata_q <= mem[vram_b_addr];
        end
    end

    tto_console_writer dut (
        .clk_pix      (clk_pix),
        .rst_n        (rst_n),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_color   (char_color),
        .char_ready   (char_ready),
        .vram_b_en    (vram_b_en),
        .vram_b_we    (vram_b_we),
        .vram_b_addr  (vram_b_addr),
        .vram_b_wdata (vram_b_wdata),
        .vram_b_rdata (vram_b_rdata),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .busy         (busy)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_blank();
        for (int x = 0; x < 80; x++)
            for (int y = 0; y < 32; y++)
                scr[x][y] = 16'hFF20;
    endtask

    task automatic model_newline();
        if (my < 29) begin
            my++;
        end else begin
            for (int y = 0; y < 29; y++)
                for (int x = 0; x < 80; x++)
                    scr[x][y] = scr[x][y+1];
            for (int x = 0; x < 80; x++) scr[x][29] = 16'hFF20;
            exp_busy += 2 * 80 * 29 + 80;
            exp_wr   += 80 * 29 + 80;
        end
    endtask

    task automatic model_char(input logic [7:0] ch, input logic [7:0] col);
        int t;
        exp_busy = 0;
        exp_wr   = 0;
        if (ch >= 8'h20 && ch != 8'h7F) begin
            scr[mx][my] = {col, ch};
            exp_busy = 1;
            exp_wr   = 1;
            if (mx < 79) mx++;
            else begin
                mx = 0;
                model_newline();
            end
        end else if (ch == 8'h0D) begin
            mx = 0;
        end else if (ch == 8'h0A) begin
            model_newline();
        end else if (ch == 8'h08) begin
            if (mx > 0) mx--;
        end else if (ch == 8'h09) begin
            t  = (mx | 7) + 1;
            mx = (t > 79) ? 79 : t;
        end else if (ch == 8'h0C) begin
            model_blank();
            mx = 0;
            my = 0;
            exp_busy = 2560;
            exp_wr   = 2560;
        end
    endtask

    // Observe one operation from the cycle after acceptance until busy drops.
    task automatic monitor_op(input int bound);
        bit done = 0;
        m_busy = 0; m_wr = 0; m_en = 0; m_rlow = 0; m_badaddr = 0; m_nonblank = 0;
        m_addr = 13'd0; m_data = 16'h0000;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_pix);
            if (vram_b_en) begin
                m_en++;
                if (vram_b_addr >= 13'd2560) m_badaddr++;
            end
            if (vram_b_en && vram_b_we) begin
                m_wr++;
                m_addr = vram_b_addr;
                m_data = vram_b_wdata;
                if (vram_b_wdata !== 16'hFF20) m_nonblank++;
                if (vram_b_addr < 13'd2560) seen[vram_b_addr] = 1'b1;
            end
            if (!char_ready) m_rlow++;
            if (busy) m_busy++;
            else begin
                done = 1;
                break;
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] ch, input logic [7:0] col);
        int w = 0;
        while (char_ready !== 1'b1 && w < 10000) begin
            @(negedge clk_pix);
            w++;
        end
        if (w >= 10000) chk("ready_timeout", 32'd0, 32'd1);
        char_valid = 1'b1;
        char_data  = ch;
        char_color = col;
        @(posedge clk_pix);
        #1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        model_char(ch, col);
        monitor_op(6000);
    endtask

    task automatic send_chk(input string tag, input logic [7:0] ch, input logic [7:0] col);
        send(ch, col);
        chk({tag, "_x"}, 32'(cursor_x), mx);
        chk({tag, "_y"}, 32'(cursor_y), my);
        chk({tag, "_busy"}, m_busy, exp_busy);
        chk({tag, "_writes"}, m_wr, exp_wr);
        chk({tag, "_addr_range"}, m_badaddr, 0);
        if (exp_busy == 0) chk({tag, "_no_strobe"}, m_en, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus"}, {vram_b_en, vram_b_we, vram_b_addr, vram_b_wdata}, 32'd0);
        chk({tag, "_ctl"}, {cursor_x, cursor_y, busy, char_ready}, 32'd0);
    endtask

    task automatic clear_run(input string tag);
        int distinct = 0;
        for (int a = 0; a < 2560; a++) seen[a] = 1'b0;
        monitor_op(3000);
        for (int a = 0; a < 2560; a++) distinct += int'(seen[a]);
        chk({tag, "_writes"}, m_wr, 2560);
        chk({tag, "_cover"}, distinct, 2560);
        chk({tag, "_blank"}, m_nonblank, 0);
        chk({tag, "_x"}, 32'(cursor_x), 0);
        chk({tag, "_y"}, 32'(cursor_y), 0);
        chk({tag, "_ready"}, 32'(char_ready), 1);
        model_blank();
        mx = 0;
        my = 0;
    endtask

    task automatic cmp_vram(input string tag);
        int bad = 0;
        for (int x = 0; x < 80; x++)
            for (int y = 0; y < 32; y++)
                if (mem[x*32+y] !== scr[x][y]) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        logic [7:0] c;
        int         r, bad;

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        char_color = 8'h00;
        repeat (3) @(posedge clk_pix);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk_pix);
        rst_n = 1'b1;
        clear_run("reset_clear");
        cmp_vram("vram_after_reset");

        // First printable character at the home position.
        send_chk("char_A", 8'h41, 8'hE0);
        chk("char_A_addr", m_addr, 32'h0000);
        chk("char_A_data", m_data, 32'hE041);
        chk("char_A_ready_low", m_rlow, 1);
        chk("char_A_cx", 32'(cursor_x), 1);

        // Walk to (79,5) and write at the right edge.
        send_chk("cr", 8'h0D, 8'h00);
        for (int i = 0; i < 5; i++) send_chk("lf", 8'h0A, 8'h00);
        for (int i = 0; i < 10; i++) send_chk("tab", 8'h09, 8'h00);
        chk("pos_79_x", 32'(cursor_x), 79);
        chk("pos_79_y", 32'(cursor_y), 5);
        send_chk("char_Z", 8'h5A, 8'h1C);
        chk("char_Z_addr", m_addr, {19'd0, 1'b0, 7'd79, 5'd5});
        chk("char_Z_data", m_data, 32'h1C5A);
        chk("wrap_x", 32'(cursor_x), 0);
        chk("wrap_y", 32'(cursor_y), 6);

        send_chk("bs_at_0", 8'h08, 8'h00);
        chk("bs_at_0_x", 32'(cursor_x), 0);
        for (int i = 0; i < 9; i++) send_chk("tab72", 8'h09, 8'h00);
        for (int i = 0; i < 5; i++) send_chk("fill77", 8'h2E, 8'h03);
        chk("pos_77_x", 32'(cursor_x), 77);
        send_chk("tab_at_77", 8'h09, 8'h00);
        chk("tab_at_77_x", 32'(cursor_x), 79);

        // Randomised mix of printables and control bytes.
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 15);
            case (r)
                0: c = 8'h0A;
                1: c = 8'h0D;
                2: c = 8'h08;
                3: c = 8'h09;
                4: begin
                    c = 8'($urandom_range(0, 31));
                    if (c == 8'h08 || c == 8'h09 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h7F;
                end
                5: c = ($urandom_range(0, 7) == 0) ? 8'h0C : 8'h41;
                default: begin
                    c = 8'($urandom_range(32, 255));
                    if (c == 8'h7F) c = 8'h80;
                end
            endcase
            send_chk("rand", c, 8'($urandom));
        end
        cmp_vram("vram_after_random");

        // Distinct row 1, then scroll it up from the last row.
        send_chk("ff", 8'h0C, 8'h00);
        send_chk("lf_row1", 8'h0A, 8'h00);
        for (int i = 0; i < 80; i++) begin
            row_ch[i]  = 8'(8'h21 + i);
            row_col[i] = 8'(i * 3 + 1);
            send_chk("row1", row_ch[i], row_col[i]);
        end
        for (int i = 0; i < 27; i++) send_chk("lf_down", 8'h0A, 8'h00);
        chk("before_scroll_y", 32'(cursor_y), 29);
        send_chk("scroll", 8'h0A, 8'h00);
        chk("scroll_busy", m_busy, 4720);
        chk("scroll_y", 32'(cursor_y), 29);
        bad = 0;
        for (int x = 0; x < 80; x++)
            if (mem[x*32] !== {row_col[x], row_ch[x]}) bad++;
        chk("scroll_row0", bad, 0);
        bad = 0;
        for (int x = 0; x < 80; x++)
            if (mem[x*32+29] !== 16'hFF20) bad++;
        chk("scroll_row29_blank", bad, 0);
        cmp_vram("vram_after_scroll");

        // Auto-wrap on the last row: write cycle then scroll.
        for (int i = 0; i < 80; i++) send_chk("wrap_fill", 8'($urandom_range(32, 126)), 8'($urandom));
        chk("autowrap_busy", m_busy, 4721);
        chk("autowrap_x", 32'(cursor_x), 0);
        cmp_vram("vram_after_autowrap");

        // Abort a scroll with reset, then expect a fresh clear.
        char_valid = 1'b1;
        char_data  = 8'h0A;
        char_color = 8'h00;
        @(posedge clk_pix);
        #1;
        char_valid = 1'b0;
        repeat (999) @(posedge clk_pix);
        #1;
        chk("midscroll_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk_pix);
        rst_n = 1'b1;
        clear_run("abort_clear");
        cmp_vram("vram_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tto_console_writer.md
# tto_console_writer

Teletype-output (TTO) console writer: accepts a byte stream of ASCII characters with per-character RGB332 colour and writes them into the 80x32 colour-ASCII VRAM that the text display scans out. It keeps the cursor, interprets CR/LF/BS/TAB/FF, and scrolls the screen in hardware with read-copy-write cycles. It sits between the CPU/UART character source and VRAM port B. The display side owns port A.

## Interface
- COLS, 80, visible columns (x range 0..COLS-1)
- ROWS, 30, visible rows used by the cursor (y range 0..ROWS-1)
- BLANK_COLOR, 8'hFF, RGB332 colour written with 0x20 for cleared cells
- CLEAR_ON_RESET, 1'b1, 1: enter full-screen clear on reset release

- clk_pix  in  1  pixel-domain clock
- rst_n  in  1  reset, asynchronous, active-low
- char_valid  in  1  source has a character
- char_data  in  8  character byte
- char_color  in  8  RGB332 foreground for printable characters
- char_ready  out  1  block accepts a character this cycle
- vram_b_en  out  1  VRAM port B enable
- vram_b_we  out  1  VRAM port B write enable
- vram_b_addr  out  13  {1'b0, x[6:0], y[4:0]}
- vram_b_wdata  out  16  {RGB332, ascii}
- vram_b_rdata  in  16  port B read data, valid the cycle after a read is sampled
- cursor_x  out  7  current column
- cursor_y  out  5  current row
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_CLR.
- Transfer occurs on a clock edge with char_valid && char_ready. char_ready = (state == IDLE), so it is low in every other state.
- Printable bytes are 0x20..0x7E and 0x80..0xFF.
  - IDLE→WRITE. Write {char_color, char_data} at the cursor.
  - If x < COLS-1, then x++.
  - Otherwise x=0 and a newline is performed.
- 0x0D CR: x=0. Stay in IDLE.
- 0x0A LF: newline. x is unchanged.
- 0x08 BS: if x>0, then x--. Nothing is erased.
- 0x09 TAB: x = min((x|7)+1, COLS-1).
- 0x0C FF: go to CLEAR. All 2560 cells (y 0..31, x 0..79) are written {BLANK_COLOR, 8'h20}. The cursor goes to (0,0).
- All other control bytes (0x00–0x1F, 0x7F) are consumed and ignored.
- Newline:
  - If y < ROWS-1, then y++.
  - Otherwise go to SCROLL. The cursor row stays at ROWS-1.
- SCROLL:
  - Loops over dst row y = 0..ROWS-2 (outer) and x = 0..COLS-1 (inner).
  - SCROLL_RD issues a read of (x, y+1).
  - SCROLL_WR writes (x, y) with vram_b_wdata = vram_b_rdata, passed combinationally, colour preserved.
  - SCROLL_CLR then writes row ROWS-1, x = 0..COLS-1, with the blank cell.
  - Then IDLE.
- Reset:
  - All outputs are 0: en, we, addr, wdata, cursor, busy. char_ready is also 0.
  - State is CLEAR if CLEAR_ON_RESET, else IDLE.
  - Asserting rst_n low mid-scroll or mid-clear aborts immediately. A partially moved screen is acceptable.

## Timing
- VRAM strobes (en, we, addr, wdata except the scroll passthrough) are registered.
- Printable character:
  - Accept at edge k. Write strobes are high during cycle k..k+1.
  - char_ready is low for 1 cycle. Peak throughput is 1 char per 2 cycles.
- CR, BS, TAB, ignored controls, and LF with y < ROWS-1: handled in IDLE. char_ready stays high; back-to-back accept is allowed.
- Scroll:
  - Cost is 2·COLS·(ROWS-1) + COLS cycles, which is 4720 with defaults.
  - If a scroll is caused by an auto-wrap write, the write cycle precedes it, for 4721 cycles total.
- Clear: 32·COLS = 2560 cycles. CLEAR_ON_RESET clear starts on the first edge after rst_n deasserts.
- cursor_x and cursor_y update on the accept edge for IDLE-handled bytes. Otherwise they update on the final edge of the operation.
- Address arithmetic: x is 7-bit and y is 5-bit. The src row is y+1 ≤ ROWS-1, so it never wraps. addr[12] is always 0.
- Read data is consumed only in SCROLL_WR, exactly one cycle after the SCROLL_RD strobe.

## Test plan
- Reset with CLEAR_ON_RESET=1 → 2560 writes of 16'hFF20 covering addr 0..2559, then char_ready=1 with cursor (0,0).
- Send 'A' with colour 8'hE0 at (0,0) → one write, addr 13'h0000, data 16'hE041; cursor (1,0); char_ready low exactly 1 cycle.
- Set cursor to (79,5) via TAB/char sequence, then send 'Z' → write addr {1'b0,7'd79,5'd5}; cursor (0,6).
- Fill row 1 with distinct bytes, cursor at y=29, send LF:
  - Row 0 receives the old row 1 with colours intact.
  - Row 29 becomes 16'hFF20 at all x.
  - Busy for 4720 cycles; cursor y=29.
- BS at x=0 and TAB at x=77 → x stays 0 and x=79 respectively; no VRAM strobes.
- Pull rst_n low at scroll cycle 1000 → all outputs 0 the same cycle; clear restarts after release.
